// File: rtl/bnn_pkg.sv
// Shared constants, types and FSM state encoding for the binary conv stage.
// No ports; imported by bnn_xnor_popcount and bnn_conv_layer.
package bnn_pkg;
  localparam int IMG_DIM = 28;
  localparam int K_DIM   = 3;
  localparam int N_FILT  = 8;
  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int POP_W   = 4;

  typedef logic [IMG_DIM-1:0][IMG_DIM-1:0] pixel_map_t;
  typedef logic [K_DIM-1:0][K_DIM-1:0]     kernel_t;
  typedef logic [N_FILT-1:0]               act_vec_t;
  typedef logic [POP_W-1:0]                pop_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_t;
endpackage

// File: rtl/bnn_xnor_popcount.sv
// One filter lane: XNOR a 3x3 binary window against a 3x3 kernel and count
// matching positions (0..9).
// Ports: win  - window bits, bit i*K_DIM+j = pixel at window row i, col j
//        kern - kernel, same bit layout as win
//        pop  - number of matching positions
module bnn_xnor_popcount
  import bnn_pkg::*;
(
  input  logic [K_DIM*K_DIM-1:0] win,
  input  kernel_t                kern,
  output pop_t                   pop
);
  logic [K_DIM*K_DIM-1:0] match;

  assign match = ~(win ^ kern);

  always_comb begin
    pop = '0;
    for (int k = 0; k < K_DIM*K_DIM; k++) pop = pop + pop_t'(match[k]);
  end
endmodule

// File: rtl/bnn_conv_layer.sv
// Binary 3x3 convolution over a 28x28 image, eight filters in parallel,
// one thresholded 8-bit activation vector per window streamed out over
// valid/ready in raster order (col fastest).
// Ports: clk, reset_n (async, active low)
//        start            - level, image/kernels valid while high
//        pixels[row][col] - binary image
//        weights[f][r][c] - binary kernels
//        out_valid/out_ready/out_bits/out_row/out_col - output stream
//        busy (RUN or DRAIN), done (DONE)
// Optional build macro BNN_CONV_POPCOUNT_EN adds out_popcount, the raw
// per-filter popcount registered with out_bits.
module bnn_conv_layer
  import bnn_pkg::*;
#(
  parameter int         IMG_DIM = 28,
  parameter int         N_FILT  = 8,
  parameter logic [3:0] THRESH  = 4'd5
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [IMG_DIM-1:0][IMG_DIM-1:0]        pixels,
  input  logic [N_FILT-1:0][K_DIM-1:0][K_DIM-1:0] weights,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [N_FILT-1:0]                      out_bits,
  output logic [4:0]                             out_row,
  output logic [4:0]                             out_col,
`ifdef BNN_CONV_POPCOUNT_EN
  output logic [N_FILT-1:0][POP_W-1:0]           out_popcount,
`endif
  output logic                                   busy,
  output logic                                   done
);
  localparam int ODIM = IMG_DIM - K_DIM + 1;
  localparam int CW   = 5;
  localparam logic [CW-1:0] LAST = CW'(ODIM - 1);

  conv_state_t state_q, state_d;
  logic [CW-1:0] r_q, c_q;
  logic [K_DIM*K_DIM-1:0] win;
  logic [N_FILT-1:0][POP_W-1:0] pop;
  logic [N_FILT-1:0] bits;
  logic adv, last_pos;

  // A new vector may be loaded whenever the output register is empty or
  // being drained this edge.
  assign adv      = !out_valid || out_ready;
  assign last_pos = (r_q == LAST) && (c_q == LAST);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  // Window shared by all filter lanes; bit layout matches kernel_t packing.
  always_comb begin
    win = '0;
    for (int i = 0; i < K_DIM; i++)
      for (int j = 0; j < K_DIM; j++)
        win[i*K_DIM+j] = pixels[r_q + CW'(i)][c_q + CW'(j)];
  end

  for (genvar f = 0; f < N_FILT; f++) begin : g_filt
    bnn_xnor_popcount u_pc (.win(win), .kern(weights[f]), .pop(pop[f]));
    assign bits[f] = pop[f] >= THRESH;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (adv && last_pos) state_d = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q       <= '0;
      c_q       <= '0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_row   <= '0;
      out_col   <= '0;
`ifdef BNN_CONV_POPCOUNT_EN
      out_popcount <= '0;
`endif
    end else begin
      if (state_q == IDLE && start) begin
        r_q <= '0;
        c_q <= '0;
      end else if (state_q == RUN && adv) begin
        out_valid <= 1'b1;
        out_bits  <= bits;
        out_row   <= r_q;
        out_col   <= c_q;
`ifdef BNN_CONV_POPCOUNT_EN
        out_popcount <= pop;
`endif
        if (c_q == LAST) begin
          c_q <= '0;
          r_q <= r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end else if (state_q == DRAIN && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bnn_conv_layer.sv
// Directed bench for bnn_conv_layer: uniform images, checkerboard, threshold
// boundary, random backpressure, mid-run reset and DONE hold behaviour.
module tb_bnn_conv_layer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [27:0][27:0] pix = '0;
  logic [7:0][2:0][2:0] wts = '0;
  logic out_valid, busy, done;
  logic [7:0] out_bits;
  logic [4:0] out_row, out_col;
`ifdef BNN_CONV_POPCOUNT_EN
  logic [7:0][3:0] out_popcount;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] obs_bits [26][26];

  always #5 clk = ~clk;

  bnn_conv_layer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pixels(pix), .weights(wts),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_row(out_row), .out_col(out_col),
`ifdef BNN_CONV_POPCOUNT_EN
    .out_popcount(out_popcount),
`endif
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int r, input int c);
    logic [7:0] b;
    int cnt;
    b = '0;
    for (int f = 0; f < 8; f++) begin
      cnt = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          if (pix[r+i][c+j] === wts[f][i][j]) cnt++;
      b[f] = (cnt >= 5);
    end
    return b;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_bits"},  out_bits, 0);
    chk({tag, "_rowcol"}, {out_row, out_col}, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
  endtask

  // Raise start and follow one full pass, scoring every accepted vector
  // against the model and checking that stalled outputs hold.
  task automatic run_pass(input bit rnd, output int nvec, output int ncyc);
    int er, ec;
    bit held, rdy;
    logic [17:0] saved;
    er = 0; ec = 0; nvec = 0; ncyc = 0; held = 0; saved = '0;
    start = 1'b1;
    out_ready = 1'b1;
    while (ncyc < 4000) begin
      @(posedge clk); ncyc++;
      @(negedge clk);
      if (done) break;
      if (ncyc == 1) begin
        chk("first_edge_valid", out_valid, 0);
        chk("first_edge_busy", busy, 1);
      end
      if (held) chk("stall_hold", {out_valid, out_bits, out_row, out_col}, {1'b1, saved});
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 0;
      if (out_valid) begin
        if (rdy) begin
          chk("pos", {out_row, out_col}, {5'(er), 5'(ec)});
          chk("bits", out_bits, model(er, ec));
          if (er < 26) obs_bits[er][ec] = out_bits;
          nvec++;
          if (ec == 25) begin ec = 0; er++; end
          else ec++;
        end else begin
          held = 1;
          saved = {out_bits, out_row, out_col};
        end
      end
      out_ready = rdy;
    end
    chk("pass_done", done, 1);
    chk("vec_count", nvec, 676);
  endtask

  initial begin
    int nv, nc;
    bit found;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // A: everything matches -> all filters fire on every window
    pix = '1; wts = '1;
    run_pass(0, nv, nc);
    chk("A_cycles", nc, 678);
    chk("A_first", obs_bits[0][0], 8'hFF);
    chk("A_last", obs_bits[25][25], 8'hFF);
    repeat (5) @(negedge clk);
    chk("A_hold_done", done, 1);
    chk("A_hold_valid", out_valid, 0);
    chk("A_hold_busy", busy, 0);
    start = 1'b0;
    @(negedge clk);
    chk("A_idle_done", done, 0);

    // B: no matches anywhere
    pix = '0; wts = '1;
    run_pass(0, nv, nc);
    chk("B_first", obs_bits[0][0], 8'h00);
    chk("B_mid", obs_bits[13][7], 8'h00);
    start = 1'b0;
    @(negedge clk);

    // C: checkerboard image and filter-0 kernel, random other kernels,
    // random backpressure
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) pix[r][c] = 1'((r + c) % 2);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) wts[0][i][j] = 1'((i + j) % 2);
    for (int f = 1; f < 8; f++) wts[f] = 9'($urandom);
    run_pass(1, nv, nc);
    chk("C_00_f0", obs_bits[0][0][0], 1);
    chk("C_01_f0", obs_bits[0][1][0], 0);
    chk("C_10_f0", obs_bits[1][0][0], 0);
    chk("C_11_f0", obs_bits[1][1][0], 1);
    start = 1'b0;
    @(negedge clk);

    // D: blank image, match counts per filter 9,5,4,0,6,3,1,5 -> 8'h93
    pix = '0;
    wts[0] = 9'h000; wts[1] = 9'h00F; wts[2] = 9'h01F; wts[3] = 9'h1FF;
    wts[4] = 9'h007; wts[5] = 9'h03F; wts[6] = 9'h0FF; wts[7] = 9'h0F0;
    run_pass(0, nv, nc);
    chk("D_first", obs_bits[0][0], 8'h93);
    chk("D_last", obs_bits[25][25], 8'h93);
    start = 1'b0;
    @(negedge clk);

    // E: reset at (10,3), restart with start held, then no second pass
    start = 1'b1;
    out_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (out_valid && out_row == 5'd10 && out_col == 5'd3) begin
        found = 1;
        break;
      end
    end
    chk("E_reach_10_3", found, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("E_async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    run_pass(0, nv, nc);
    repeat (10) @(negedge clk);
    chk("E_no_rerun_done", done, 1);
    chk("E_no_rerun_busy", busy, 0);
    chk("E_no_rerun_valid", out_valid, 0);
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
